// File: rtl/uart_tx_loader_if.sv
// Bus between the byte producer / UART transmitter and uart_tx_loader.
// The master side is whatever drives the producer and UART inputs.
interface uart_tx_loader_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              enable;
  logic              tx_empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              busy;
  logic              ld_tx_data;
  logic [7:0]        tx_data;
  logic              tx_enable;

  modport master (
    output wr_en, wr_data, enable, tx_empty,
    input  full, count, overflow, busy, ld_tx_data, tx_data, tx_enable
  );

  modport slave (
    input  wr_en, wr_data, enable, tx_empty,
    output full, count, overflow, busy, ld_tx_data, tx_data, tx_enable
  );
endinterface

// File: rtl/uart_tx_loader.sv
// Byte FIFO in front of the UART transmitter: pops one byte per idle UART,
// waiting for tx_empty to fall and rise again before the next load.
module uart_tx_loader #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic            txclk,
  input  logic            reset,
  uart_tx_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_e;

  state_e              state_q, state_d;
  logic [7:0]          mem_q [DEPTH];
  logic [ADDR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [ADDR_W:0]     count_q, count_d;
  logic                overflow_q, tx_enable_q;
  logic [7:0]          tx_data_q;
  logic                full, pop, push, drop;

  assign full = (count_q == (ADDR_W+1)'(DEPTH));
  assign pop  = (state_q == IDLE) && (count_q != '0) && bus.enable && bus.tx_empty;
  // a pop frees a slot on the same edge, so a full FIFO can still take a byte
  assign push = bus.wr_en && (!full || pop);
  assign drop = bus.wr_en && full && !pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pop) state_d = LOAD;
      LOAD:      state_d = WAIT_BUSY;
      WAIT_BUSY: if (!bus.tx_empty) state_d = WAIT_DONE;
      WAIT_DONE: if (bus.tx_empty) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge txclk) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      tx_enable_q <= 1'b0;
      tx_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      tx_enable_q <= bus.enable;
      if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + ADDR_W'(1);
        tx_data_q <= mem_q[rd_ptr_q];
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  // storage needs no reset; pointers and count define what is valid
  always_ff @(posedge txclk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.full       = full;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = (count_q != '0) || (state_q != IDLE);
  assign bus.ld_tx_data = (state_q == LOAD);
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_enable  = tx_enable_q;
endmodule

// File: tb/tb_uart_tx_loader.sv
// Directed + randomized bench for uart_tx_loader with a behavioural UART
// model and an in-order byte scoreboard.
module tb_uart_tx_loader;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic txclk = 1'b0;
  logic reset;
  uart_tx_loader_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus();
  uart_tx_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (.txclk(txclk), .reset(reset), .bus(bus));

  always #5 txclk = ~txclk;

  int tests = 0;
  int fails = 0;
  byte unsigned rx[$];
  byte unsigned exp_q[$];
  int lat_lo = 1, lat_hi = 1, stall_n = 0, st = 0, ucnt = 0, since_ld = 100;
  logic prev_ld = 1'b0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(string tag);
    tests++;
    fails++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  // UART model: after a load, tx_empty drops (optionally after a stall),
  // stays low for a random number of cycles, then rises again.
  always @(negedge txclk) begin
    since_ld++;
    if (reset) begin
      bus.tx_empty = 1'b1;
      st = 0;
      ucnt = 0;
      prev_ld = 1'b0;
    end else begin
      if (bus.ld_tx_data) begin
        check("ld_single_pulse", {31'd0, prev_ld}, 0);
        check("ld_spacing_ge4", {31'd0, since_ld >= 4}, 1);
        rx.push_back(bus.tx_data);
        since_ld = 0;
        ucnt = $urandom_range(lat_hi, lat_lo);
        if (stall_n > 0) begin
          st = stall_n;
          stall_n = 0;
        end else bus.tx_empty = 1'b0;
      end else if (st > 0) begin
        st--;
        if (st == 0) bus.tx_empty = 1'b0;
      end else if (!bus.tx_empty) begin
        if (ucnt > 0) ucnt--;
        else bus.tx_empty = 1'b1;
      end
      prev_ld = bus.ld_tx_data;
    end
  end

  task automatic step();
    @(posedge txclk);
    #2;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.enable = 1'b0;
    stall_n = 0;
    step();
    step();
    reset = 1'b0;
    rx.delete();
    exp_q.delete();
  endtask

  task automatic wr_raw(byte unsigned d);
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic put(byte unsigned d);
    int k = 0;
    while (bus.full && k < 500) begin
      step();
      k++;
    end
    if (k >= 500) timeout("put_full_wait");
    wr_raw(d);
    exp_q.push_back(d);
  endtask

  task automatic wait_rx(int n);
    int k = 0;
    while (!(rx.size() >= n && !bus.busy) && k < 3000) begin
      step();
      k++;
    end
    if (k >= 3000) timeout("wait_rx");
  endtask

  task automatic cmp_rx(string tag);
    int n;
    check({tag, "_len"}, rx.size(), exp_q.size());
    n = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_byte"}, rx[i], exp_q[i]);
    rx.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // reset with garbage inputs
    reset = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'($urandom);
    bus.enable = 1'b1;
    step();
    step();
    check("rst_ld", bus.ld_tx_data, 0);
    check("rst_txdata", bus.tx_data, 0);
    check("rst_txen", bus.tx_enable, 0);
    check("rst_full", bus.full, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_count", bus.count, 0);
    check("rst_ovf", bus.overflow, 0);
    reset = 1'b0;
    bus.wr_en = 1'b0;
    bus.enable = 1'b0;
    step();
    step();

    // tx_enable latency
    bus.enable = 1'b1;
    check("txen_before", bus.tx_enable, 0);
    step();
    check("txen_after", bus.tx_enable, 1);

    // single byte from empty
    lat_lo = 2; lat_hi = 2;
    wr_raw(8'hA5);
    check("sb_count_e0", bus.count, 1);
    check("sb_ld_e0", bus.ld_tx_data, 0);
    step();
    check("sb_ld_e1", bus.ld_tx_data, 1);
    check("sb_data_e1", bus.tx_data, 8'hA5);
    check("sb_count_e1", bus.count, 0);
    step();
    check("sb_ld_e2", bus.ld_tx_data, 0);
    check("sb_busy_e2", bus.busy, 1);
    exp_q.push_back(8'hA5);
    wait_rx(1);
    check("sb_busy_done", bus.busy, 0);
    check("sb_data_hold", bus.tx_data, 8'hA5);
    cmp_rx("single");

    // reset in the middle of LOAD
    wr_raw(8'h5A);
    step();
    check("ml_ld_pre", bus.ld_tx_data, 1);
    reset = 1'b1;
    step();
    check("ml_ld", bus.ld_tx_data, 0);
    check("ml_busy", bus.busy, 0);
    check("ml_count", bus.count, 0);
    check("ml_txdata", bus.tx_data, 0);
    reset = 1'b0;
    rx.delete();
    step();

    // ordering and pointer wrap with a slow UART
    reset_dut();
    bus.enable = 1'b1;
    lat_lo = 8; lat_hi = 8;
    for (int i = 1; i <= 12; i++) put(8'(i));
    wait_rx(12);
    cmp_rx("order");
    check("order_ovf", bus.overflow, 0);

    // full and overflow
    reset_dut();
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 9; i++) begin
      wr_raw(8'h10 + 8'(i));
      if (i == 7) begin
        check("ovf_full8", bus.full, 1);
        check("ovf_count8", bus.count, 8);
        check("ovf_flag8", bus.overflow, 0);
      end
    end
    check("ovf_flag9", bus.overflow, 1);
    check("ovf_count9", bus.count, 8);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h10 + 8'(i));
    bus.enable = 1'b1;
    wait_rx(8);
    cmp_rx("ovf");
    check("ovf_sticky", bus.overflow, 1);

    // push/pop collision while full
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      wr_raw(8'h20 + 8'(i));
      exp_q.push_back(8'h20 + 8'(i));
    end
    check("col_full", bus.full, 1);
    bus.enable = 1'b1;
    wr_raw(8'hEE);
    exp_q.push_back(8'hEE);
    check("col_count", bus.count, 8);
    check("col_ovf", bus.overflow, 0);
    check("col_ld", bus.ld_tx_data, 1);
    check("col_data", bus.tx_data, 8'h20);
    wait_rx(9);
    cmp_rx("col");

    // handshake stall: tx_empty held high after a load
    reset_dut();
    bus.enable = 1'b1;
    lat_lo = 2; lat_hi = 3;
    stall_n = 5;
    put(8'hA1);
    put(8'hB2);
    k = 0;
    while (!bus.ld_tx_data && k < 50) begin
      step();
      k++;
    end
    if (k >= 50) timeout("stall_first_ld");
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_no_ld", bus.ld_tx_data, 0);
      check("stall_busy", bus.busy, 1);
    end
    wait_rx(2);
    cmp_rx("stall");

    // randomized traffic with enable toggling
    reset_dut();
    bus.enable = 1'b1;
    lat_lo = 1; lat_hi = 6;
    for (int i = 0; i < 40; i++) begin
      int gap = $urandom_range(3, 0);
      for (int g = 0; g < gap; g++) step();
      if ($urandom_range(7, 0) == 0) bus.enable = 1'($urandom_range(1, 0));
      if (bus.full) bus.enable = 1'b1;
      put(8'($urandom));
    end
    bus.enable = 1'b1;
    wait_rx(40);
    cmp_rx("rand");
    check("rand_ovf", bus.overflow, 0);
    check("rand_count", bus.count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_loader.md
# uart_tx_loader

Byte-buffering front end for the UART transmit side. Accepts bytes from a producer through a write-strobe FIFO and hands them one at a time to the UART transmitter, pulsing `ld_tx_data` only when the transmitter reports `tx_empty`. It is clocked on the transmitter clock and sits directly upstream of the UART's `ld_tx_data` / `tx_data` / `tx_enable` / `tx_empty` ports.

## Interface
- `DEPTH`, 8: FIFO depth in bytes; power of two, ≥ 2.
- `ADDR_W`, 3: log2(`DEPTH`).

Ports:
- `txclk` in 1: the only clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `wr_en` in 1: producer write strobe.
- `wr_data` in 8: byte written when `wr_en`=1 and the write is accepted.
- `enable` in 1: transmit enable request.
- `tx_empty` in 1: from UART; 1 = transmitter idle and ready to load.
- `full` out 1: FIFO holds `DEPTH` bytes.
- `count` out `ADDR_W`+1: bytes currently buffered (0..`DEPTH`).
- `overflow` out 1: sticky; a write was dropped.
- `busy` out 1: `count`≠0 or state≠IDLE.
- `ld_tx_data` out 1: one-cycle load pulse to UART.
- `tx_data` out 8: byte to UART, stable from the load cycle until the next load.
- `tx_enable` out 1: to UART; registered copy of `enable`.

## Operation
- FIFO: circular buffer, `rd_ptr`/`wr_ptr` of `ADDR_W` bits wrapping modulo `DEPTH`, plus `count`.
- A write is accepted when `wr_en`=1 and (`full`=0, or a pop occurs in the same cycle).
- A write with `full`=1 and no pop is dropped, sets `overflow`=1, and leaves the FIFO unchanged.
- FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
  - IDLE → LOAD when `count`≠0, `enable`=1 and `tx_empty`=1.
    - On this edge: `tx_data` ← mem[`rd_ptr`], `rd_ptr`++, `count`-- (the pop).
  - LOAD: `ld_tx_data`=1 for exactly this one cycle; then → WAIT_BUSY unconditionally.
  - WAIT_BUSY: stays until `tx_empty`=0, then → WAIT_DONE. This prevents a second load before the UART has registered the first.
  - WAIT_DONE: stays until `tx_empty`=1, then → IDLE.
- `enable` deasserted: the in-flight byte completes normally; no new pop starts from IDLE. Buffered bytes are retained.
- Simultaneous push and pop:
  - `count` unchanged.
  - Allowed when `full`=1.
  - Allowed when `count`=1; the popped byte is the old head, and the new byte remains buffered.
- A write in the same cycle the FIFO is empty is never forwarded combinationally. It must be registered first.
- `full` = (`count`==`DEPTH`). `count`, `full` and `busy` are registered or derived only from registered state.

## Timing
- Reset (synchronous, any state, including mid-LOAD or mid-WAIT):
  - FSM → IDLE; pointers, `count` and `overflow` cleared.
  - Outputs: `ld_tx_data`=0, `tx_data`=8'h00, `tx_enable`=0, `full`=0, `busy`=0.
  - FIFO contents are discarded.
- Write latency: write sampled at edge E0 → `count` updated after E0.
- Load latency from empty (`enable`=1, `tx_empty`=1): write at E0 → IDLE→LOAD at E1 → `ld_tx_data`=1 and `tx_data` valid in the cycle after E1.
- Back-to-back bytes: the next pop needs WAIT_DONE→IDLE (one edge) plus IDLE→LOAD (one edge). Minimum spacing between `ld_tx_data` pulses is 4 cycles when `tx_empty` toggles with 1-cycle latency.
- `tx_enable` follows `enable` with 1 cycle of latency.
- `overflow` is set on the edge of the dropped write and is cleared only by `reset`.

## Test plan
- Reset: drive garbage inputs, assert `reset` 2 cycles → all outputs 0, `count`=0; repeat with `reset` asserted mid-LOAD → `ld_tx_data` is 0 on the next cycle.
- Single byte: `enable`=1, UART model idle, write 8'hA5 at E0 → `ld_tx_data` is a single pulse after E1 with `tx_data`=8'hA5; `count` returns to 0; `busy` drops after `tx_empty` returns to 1.
- Ordering and wrap: write 8'h01..8'h0C across 12 cycles while the UART model takes 10 cycles per byte → bytes emitted in order 01..0C, no duplicates, pointers wrap, `overflow`=0.
- Full and overflow: `enable`=0, write 9 bytes 8'h10..8'h18 → `full`=1 after 8 writes, the ninth byte is dropped, `overflow`=1; then `enable`=1 → exactly 10..17 are emitted.
- Push/pop collision: with `full`=1, write 8'hEE in the IDLE→LOAD cycle → accepted, `count` stays 8, `overflow` unchanged, 8'hEE emitted last.
- Handshake stall: hold `tx_empty`=1 for 5 cycles after a load → FSM stays in WAIT_BUSY and no second `ld_tx_data` occurs; drop then raise `tx_empty` → the next byte loads.
